// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared types and constants for the bit-serial adder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: must hold WIDTH-1.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
// Module  : fa
// Brief   : One-bit full-adder cell.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder, one bit pair per clock, LSB first.
//           Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_o,
`endif
    output logic             cout_o
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               w_fa_s;
    logic               w_fa_cout;
    logic               w_last;

    fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .c    (carry_q),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (w_last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == IDLE && start_i) begin
            a_sh_d  = a_i;
            b_sh_d  = b_i;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = cin_i;
        end else if (state_q == RUN) begin
            // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
            sum_d   = {w_fa_s, sum_q[WIDTH-1:1]};
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = w_fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (w_last) begin
                cout_d = w_fa_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit, carry_q is the carry into the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && start_i) begin
            ovf_d = 1'b0;
        end else if (state_q == RUN && w_last) begin
            ovf_d = carry_q ^ w_fa_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Directed self-checking bench for serial_adder (WIDTH=8).
//           Checks ovf_o as well when SERIAL_ADDER_OVF_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf_o   (ovf),
`endif
        .cout_o  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_result(input string tag, input logic [W-1:0] es, input logic ec);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " sum"},  32'(sum),  32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
    endtask

    // Single start pulse; checks busy for W cycles, the done pulse and the result.
    task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        start = 1'b1; a = ta; b = tb; cin = tc;
        tick();
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " nodone"}, 32'(done), 32'd0);
            if (i < W - 1) tick();
        end
        tick();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unused overflow expectation");
`endif
        tick();
        check({tag, " done_clr"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        check_idle_result("reset", 8'h00, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        run_add("5A+3C",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_add("FF+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_add("7F+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_add("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_add("40+20",   8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0);

        // start re-asserted during RUN must be ignored
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < W - 1; i++) begin
            if (i == W - 3) start = 1'b0;
            check("ign busy", 32'(busy), 32'd1);
            tick();
        end
        check("ign busy last", 32'(busy), 32'd1);
        tick();
        check("ign done", 32'(done), 32'd1);
        check("ign sum", 32'(sum), 32'h30);
        check("ign cout", 32'(cout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle_result("ign hold", 8'h30, 1'b0);
        end

        // reset on the 4th RUN cycle of AA+55
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre-rst busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_result("midrst", 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst nodone", 32'(done), 32'd0);
        end
        run_add("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // rst and start at the same edge: rst wins
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        tick();
        rst = 1'b0; start = 1'b0;
        check_idle_result("rst+start", 8'h00, 1'b0);
        tick();
        check("rst+start idle", 32'(busy), 32'd0);

        // start held high: accepts every W+2 edges
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        tick();
        a = 8'h0F; b = 8'h01;
        for (int i = 0; i < W - 1; i++) tick();
        check("b2b1 pre", 32'(done), 32'd0);
        tick();
        check("b2b1 done", 32'(done), 32'd1);
        check("b2b1 sum", 32'(sum), 32'h46);
        tick();
        check("b2b idle", 32'(busy), 32'd0);
        tick();
        check("b2b2 busy", 32'(busy), 32'd1);
        a = 8'h00; b = 8'h00; start = 1'b0;
        for (int i = 0; i < W - 1; i++) tick();
        check("b2b2 pre", 32'(done), 32'd0);
        tick();
        check("b2b2 done", 32'(done), 32'd1);
        check("b2b2 sum", 32'(sum), 32'h10);
        check("b2b2 cout", 32'(cout), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
